// File: rtl/imem_if.sv
// imem_if - bundle of the fetch, loader and memory-port signals of imem_ctrl.
//
// Signals (direction seen from the controller, modport slave):
//   fetch_req   in   CPU word-fetch request
//   fetch_addr  in   32-bit byte address of the fetch
//   fetch_ready out  fetch accepted when fetch_req && fetch_ready
//   fetch_valid out  one-cycle result pulse
//   fetch_inst  out  assembled little-endian instruction word
//   fetch_err   out  accepted address was misaligned or out of range
//   load_valid  in   loader presents a byte write
//   load_addr   in   loader byte address (ADDR_W)
//   load_data   in   loader byte
//   load_ready  out  write performed when load_valid && load_ready
//   mem_addr    out  memory byte address (ADDR_W)
//   mem_we      out  memory write enable
//   mem_wdata   out  memory write byte
//   mem_rdata   in   memory read byte, combinational from mem_addr
//   busy        out  controller is not idle
// The master modport is the requester/memory side.
interface imem_if #(
   parameter int ADDR_W = 10
);
   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_ready;
   logic              fetch_valid;
   logic [31:0]       fetch_inst;
   logic              fetch_err;
   logic              load_valid;
   logic [ADDR_W-1:0] load_addr;
   logic [7:0]        load_data;
   logic              load_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              busy;

   modport master (
      output fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      input  fetch_ready, fetch_valid, fetch_inst, fetch_err, load_ready,
             mem_addr, mem_we, mem_wdata, busy
   );

   modport slave (
      input  fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      output fetch_ready, fetch_valid, fetch_inst, fetch_err, load_ready,
             mem_addr, mem_we, mem_wdata, busy
   );
endinterface

// File: rtl/imem_ctrl.sv
// imem_ctrl - shares the single byte port of the instruction memory between
// the CPU fetch stage and a program loader. A word fetch is four byte reads
// assembled little-endian (byte at addr lands in bits 7:0). Loader writes win
// arbitration, but only LOAD_BURST times in a row while a fetch is waiting.
//
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  imem_if.slave: fetch request/response, loader write port, memory port
//
// Build option: define IMEM_LOAD_EN to include the loader port and the
// arbitration/streak logic; without it the loader is ignored and the memory
// is only ever read.
module imem_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int LOAD_BURST = 4
) (
   input logic   clk,
   input logic   rst,
   imem_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Highest legal word base: the last full word must fit in the memory.
   localparam logic [32:0] MAX_ADDR = (33'd1 << ADDR_W) - 33'd4;

   logic [1:0]        r_state;
   logic [1:0]        r_k;
   logic [ADDR_W-1:0] r_base;
   logic [23:0]       r_acc;
   logic [31:0]       r_inst;
   logic              r_err;

   logic              w_idle;
   logic              w_load_gnt;
   logic              w_fetch_gnt;
   logic              w_bad;
   logic [ADDR_W-1:0] w_ld_addr;
   logic [7:0]        w_ld_data;

   assign w_idle = (r_state == S_IDLE);

`ifdef IMEM_LOAD_EN
   localparam int SW = $clog2(LOAD_BURST + 1);

   logic [SW-1:0] r_streak;
   logic          w_starve;

   // A waiting fetch that has already seen LOAD_BURST loads wins the port.
   assign w_starve   = bus.fetch_req && (r_streak == SW'(LOAD_BURST));
   assign w_load_gnt = !rst && w_idle && bus.load_valid && !w_starve;
   assign w_ld_addr  = bus.load_addr;
   assign w_ld_data  = bus.load_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_streak <= '0;
      end else if (w_fetch_gnt) begin
         r_streak <= '0;
      end else if (w_load_gnt && bus.fetch_req && (r_streak != SW'(LOAD_BURST))) begin
         r_streak <= r_streak + 1'b1;
      end
   end
`else
   logic w_unused_load;

   assign w_unused_load = ^{bus.load_valid, bus.load_addr, bus.load_data};
   assign w_load_gnt    = 1'b0;
   assign w_ld_addr     = '0;
   assign w_ld_data     = '0;
`endif

   assign w_fetch_gnt = !rst && w_idle && bus.fetch_req && !w_load_gnt;
   assign w_bad       = (bus.fetch_addr[1:0] != 2'b00) || ({1'b0, bus.fetch_addr} > MAX_ADDR);

   assign bus.fetch_ready = !rst && w_idle && !w_load_gnt;
   assign bus.load_ready  = w_load_gnt;
   assign bus.mem_we      = w_load_gnt;
   assign bus.mem_wdata   = w_load_gnt ? w_ld_data : 8'h00;
   assign bus.mem_addr    = w_load_gnt          ? w_ld_addr :
                            (r_state == S_RD)   ? r_base + ADDR_W'(r_k) :
                                                  '0;
   assign bus.fetch_valid = (r_state == S_RESP);
   assign bus.fetch_inst  = r_inst;
   assign bus.fetch_err   = r_err;
   assign bus.busy        = !w_idle;

   // Control: state, byte counter and the visible result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_k     <= 2'd0;
         r_inst  <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fetch_gnt) begin
                  r_k   <= 2'd0;
                  r_err <= w_bad;
                  if (w_bad) begin
                     r_inst  <= '0;
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (r_k == 2'd3) begin
                  // Result is published only once the word is complete.
                  r_inst  <= {bus.mem_rdata, r_acc};
                  r_k     <= 2'd0;
                  r_state <= S_RESP;
               end else begin
                  r_k <= r_k + 2'd1;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Data: fetch base and the three low bytes of the word being assembled.
   always_ff @(posedge clk) begin
      if (w_fetch_gnt) begin
         r_base <= bus.fetch_addr[ADDR_W-1:0];
      end
      if (r_state == S_RD) begin
         case (r_k)
            2'd0:    r_acc[7:0]   <= bus.mem_rdata;
            2'd1:    r_acc[15:8]  <= bus.mem_rdata;
            2'd2:    r_acc[23:16] <= bus.mem_rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Sequencer and arbiter for the byte-wide instruction memory of the RISC-V core. It shares the memory's single byte port between the CPU fetch stage and a program-loader port. A word fetch is performed as four sequential byte reads, assembled little-endian, so bytes at addr..addr+3 form bits 7:0..31:24. Loader byte writes take priority, with a bounded burst so that fetch is never starved.

## Interface
- `ADDR_W`, default 10: byte-address width of the memory (1024 bytes).
- `LOAD_BURST`, default 4: maximum number of consecutive loader grants allowed while a fetch is pending.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `fetch_req` input 1: the CPU requests a word fetch.
- `fetch_addr` input 32: byte address of the fetch; sampled on accept.
- `fetch_ready` output 1: the fetch is accepted this cycle when `fetch_req && fetch_ready`.
- `fetch_valid` output 1: one-cycle pulse; `fetch_inst` and `fetch_err` are valid.
- `fetch_inst` output 32: assembled instruction word.
- `fetch_err` output 1: the accepted address was misaligned or out of range.
- `load_valid` input 1: the loader presents a byte write.
- `load_addr` input ADDR_W: loader byte address.
- `load_data` input 8: loader byte.
- `load_ready` output 1: the write is performed this cycle when `load_valid && load_ready`.
- `mem_addr` output ADDR_W: memory byte address.
- `mem_we` output 1: memory write enable.
- `mem_wdata` output 8: memory write data.
- `mem_rdata` input 8: memory read data, combinational from `mem_addr` in the same cycle.
- `busy` output 1: the FSM is not in IDLE.

## Operation
- **States:** IDLE, RD (sub-counter k = 0..3), RESP.
- **Arbitration in IDLE:**
  - If `load_valid` and not (`fetch_req` and streak == LOAD_BURST), the load is granted: `load_ready` = 1, `fetch_ready` = 0.
  - Otherwise, if `fetch_req`, the fetch is granted: `fetch_ready` = 1, `load_ready` = 0.
- **Load grant:**
  - `mem_we` = 1, `mem_addr` = `load_addr`, `mem_wdata` = `load_data`, all combinational in the same cycle.
  - The state stays IDLE.
  - If `fetch_req` is high, streak increments, saturating at LOAD_BURST.
- **Fetch grant:**
  - The base address is latched and streak is cleared.
  - If `fetch_addr[1:0]` != 0 or `fetch_addr` > 2^ADDR_W − 4: next state is RESP with the error flag set; memory is not accessed.
  - Otherwise: next state is RD with k = 0.
- **RD:**
  - `mem_addr` = base + k, `mem_we` = 0.
  - At the clock edge, `mem_rdata` is captured into inst[8k+7:8k].
  - k = 3 transitions to RESP.
  - `fetch_ready` and `load_ready` are 0.
- **RESP:**
  - `fetch_valid` = 1.
  - `fetch_inst` = assembled word, or 0 on error; `fetch_err` reflects the error flag.
  - Next state is IDLE.
  - Both ready signals are 0.
- **Hold and idle values:** `fetch_inst` holds its last value after RESP. `mem_addr` = 0 and `mem_wdata` = 0 whenever no access is in progress.
- **Reset behaviour:**
  - `rst` in any state (including mid-RD) forces IDLE, k = 0, streak = 0, `fetch_inst` = 0 and error flag = 0.
  - The partial word is discarded and no `fetch_valid` is issued.
  - While `rst` is high, `fetch_ready`, `load_ready` and `mem_we` are forced to 0.

## Timing
- **Reset values:** `fetch_valid` 0, `fetch_err` 0, `fetch_inst` 0x00000000, `fetch_ready` 0, `load_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0.
- **Fetch latency:** accept at cycle T; reads in T+1..T+4; `fetch_valid` in T+5. Earliest next accept is T+6, giving a throughput of 1 word per 6 cycles.
- **Error latency:** accept at T; `fetch_valid` with `fetch_err` = 1 in T+1.
- **Load:** one byte per cycle while granted; zero-cycle latency to the memory port.
- **Requester obligations:** `fetch_req`/`fetch_addr` and `load_*` must be held until accepted. Changes to `fetch_addr` after accept are ignored.
- **Starvation bound:** with `fetch_req` held, a fetch is granted within LOAD_BURST+1 IDLE cycles.

## Configuration
- **`IMEM_LOAD_EN` defined:** the loader port and arbitration are as described above.
- **`IMEM_LOAD_EN` undefined:**
  - The loader logic and streak counter are removed.
  - `load_ready` = 0 and `mem_we` = 0 permanently, and `mem_wdata` = 0.
  - In IDLE, `fetch_ready` = !`rst`. Fetch timing is unchanged.

## Test plan
- **Aligned fetch:** memory bytes 0..3 = 13,03,10,00 (hex); fetch addr 0 accepted at T -> `fetch_valid` at T+5 with `fetch_inst` = 0x00100313, `fetch_err` = 0; `mem_addr` = 0,1,2,3 in T+1..T+4.
- **Load then read back:** load bytes 0x93,0x0E,0x10,0x00 to addr 8..11 over 4 cycles with `mem_we` = 1 each cycle -> fetch addr 8 returns 0x00100E93.
- **Misaligned and out of range:** fetch addr 0x6 -> `fetch_valid` at T+1, `fetch_err` = 1, `fetch_inst` = 0, no RD cycles. Fetch addr 0x3FE -> error. Fetch addr 0x3FC -> normal fetch.
- **Arbitration and fairness:** `load_valid` and `fetch_req` held together with LOAD_BURST = 4 -> exactly 4 load grants, then a fetch grant in the 5th cycle; the streak resets and loads resume after RESP.
- **Reset mid-fetch:** assert `rst` in the cycle after RD k = 2 -> next cycle `busy` = 0, `fetch_inst` = 0, no `fetch_valid` pulse; a new fetch completes normally.
- **`IMEM_LOAD_EN` undefined:** `load_valid` = 1 for 10 cycles -> `load_ready` and `mem_we` stay 0, and fetches have 5-cycle latency.
